// File: rtl/ic_fetch_queue_pkg.sv
// Shared IC->ID definitions for the instruction-fetch queue.
//   IC_TO_ID_WD  : width of one IC->ID payload (excepttype, ce, pc)
//   *_LSB / *_W  : bit-field placement inside that payload
//   ic_to_id_t   : packed view of the payload, MSB first
//   log2_ceil    : pointer-width helper for power-of-two depths
package ic_fetch_queue_pkg;

  localparam int unsigned IC_TO_ID_WD = 65;

  localparam int unsigned PC_LSB  = 0;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CE_BIT  = 32;
  localparam int unsigned EXC_LSB = 33;
  localparam int unsigned EXC_W   = 32;

  typedef struct packed {
    logic [EXC_W-1:0] excepttype;
    logic             ce;
    logic [PC_W-1:0]  pc;
  } ic_to_id_t;

  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ic_fetch_queue.sv
// Instruction-fetch buffer between IC and ID: a DEPTH-entry FIFO with a
// valid/ready handshake on both sides and a one-cycle kill on flush or
// branch redirect.
//   clk, rst              : clock, synchronous active-high reset
//   flush, br_e           : kill every buffered entry (incoming entry dropped)
//   in_valid/in_ready     : IC-side handshake, in_data is the payload
//   out_valid/out_ready   : ID-side handshake, out_data is the head entry
//                           (all zero when the queue is empty)
//   count                 : current occupancy
//   almost_full           : count >= AFULL_TH, fetch back-pressure for PC
module ic_fetch_queue
  import ic_fetch_queue_pkg::*;
#(
  parameter int unsigned DATA_W   = IC_TO_ID_WD,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     br_e,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int unsigned PTR_W = log2_ceil(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  logic kill;
  logic enq;
  logic deq;

  assign kill = flush | br_e;

  always_comb begin
    in_ready    = (cnt != FULL_CNT);
    out_valid   = (cnt != '0);
    // Bubbles read as all-zero so ID never sees stale or unwritten storage.
    out_data    = out_valid ? mem[rd_ptr] : '0;
    count       = cnt;
    almost_full = (cnt >= AFULL_CNT);
  end

  assign enq = in_valid & in_ready;
  assign deq = out_valid & out_ready;

  // Pointers and occupancy; rst outranks kill, kill outranks the handshake.
  // Pointers are exactly PTR_W bits so DEPTH-1 -> 0 wraps for free.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; a write during rst/kill is harmless because the
  // pointers and count are cleared in the same edge, leaving it unreachable.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_ic_fetch_queue.sv
module tb_ic_fetch_queue;
  import ic_fetch_queue_pkg::*;

  localparam int unsigned DW = IC_TO_ID_WD;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          br_e;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count;
  logic          almost_full;

  ic_fetch_queue #(.DATA_W(DW), .DEPTH(4), .AFULL_TH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .br_e       (br_e),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count      (count),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst;
    logic          flush;
    logic          br_e;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic [2:0]    e_cnt;
    logic          e_ov;
    logic          e_ir;
    logic          e_af;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t vecs [40];
  int   nvec;
  int   checks;
  int   errors;

  logic [DW-1:0] expq [$];

  function automatic logic [DW-1:0] pl(input logic [31:0] exc, input logic ce,
                                       input logic [31:0] pc);
    ic_to_id_t p;
    p.excepttype = exc;
    p.ce         = ce;
    p.pc         = pc;
    return p;
  endfunction

  function automatic logic [DW-1:0] pcd(input logic [31:0] pc);
    return pl(32'h0, 1'b0, pc);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic b, input logic iv,
                     input logic [DW-1:0] d, input logic ordy, input logic [2:0] c,
                     input logic ov, input logic ir, input logic af,
                     input logic [DW-1:0] od);
    vecs[nvec].rst   = r;
    vecs[nvec].flush = f;
    vecs[nvec].br_e  = b;
    vecs[nvec].iv    = iv;
    vecs[nvec].d     = d;
    vecs[nvec].ordy  = ordy;
    vecs[nvec].e_cnt = c;
    vecs[nvec].e_ov  = ov;
    vecs[nvec].e_ir  = ir;
    vecs[nvec].e_af  = af;
    vecs[nvec].e_od  = od;
    nvec = nvec + 1;
  endtask

  task automatic drive(input logic r, input logic f, input logic b, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
    rst       = r;
    flush     = f;
    br_e      = b;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] z;
  logic [DW-1:0] pA, pB, pC, pD, pE, pF, pG, pH, pI, pJ, pK, pL, pM, pN, pP;

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;
    z  = '0;
    pA = pcd(32'h1c000000); pB = pcd(32'h1c000004);
    pC = pcd(32'h1c000008); pD = pcd(32'h1c00000c);
    pE = pcd(32'h1c0000e0); pF = pcd(32'h1c000020);
    pG = pcd(32'h1c000024); pH = pcd(32'h1c000028);
    pI = pcd(32'h1c000040); pJ = pcd(32'h1c000080);
    pK = pcd(32'h1c000084); pL = pcd(32'h1c000088);
    pM = pcd(32'h1c00008c); pN = pcd(32'h1c000090);
    pP = pl(32'h00000008, 1'b1, 32'h1c000010);

    //   rst  fl   br   iv   data ordy cnt  ov   ir   af   out_data
    add(1'b1,1'b0,1'b0,1'b0, z,  1'b0,3'd0,1'b0,1'b1,1'b0, z);   // reset
    add(1'b1,1'b0,1'b0,1'b0, z,  1'b0,3'd0,1'b0,1'b1,1'b0, z);
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b0,3'd0,1'b0,1'b1,1'b0, z);   // idle
    add(1'b0,1'b0,1'b0,1'b1, pA, 1'b0,3'd1,1'b1,1'b1,1'b0, pA);  // fill
    add(1'b0,1'b0,1'b0,1'b1, pB, 1'b0,3'd2,1'b1,1'b1,1'b0, pA);
    add(1'b0,1'b0,1'b0,1'b1, pC, 1'b0,3'd3,1'b1,1'b1,1'b1, pA);
    add(1'b0,1'b0,1'b0,1'b1, pD, 1'b0,3'd4,1'b1,1'b0,1'b1, pA);
    add(1'b0,1'b0,1'b0,1'b1, pE, 1'b0,3'd4,1'b1,1'b0,1'b1, pA);  // 5th refused
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b1,3'd3,1'b1,1'b1,1'b1, pB);  // drain
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b1,3'd2,1'b1,1'b1,1'b0, pC);
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b1,3'd1,1'b1,1'b1,1'b0, pD);
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b1,3'd0,1'b0,1'b1,1'b0, z);
    add(1'b0,1'b0,1'b0,1'b1, pF, 1'b1,3'd1,1'b1,1'b1,1'b0, pF);  // empty enq+deq
    add(1'b0,1'b0,1'b0,1'b1, pG, 1'b0,3'd2,1'b1,1'b1,1'b0, pF);
    add(1'b0,1'b0,1'b0,1'b1, pH, 1'b0,3'd3,1'b1,1'b1,1'b1, pF);
    add(1'b0,1'b0,1'b1,1'b1, pI, 1'b1,3'd0,1'b0,1'b1,1'b0, z);   // br_e kill
    add(1'b0,1'b0,1'b0,1'b1, pJ, 1'b0,3'd1,1'b1,1'b1,1'b0, pJ);
    add(1'b0,1'b0,1'b0,1'b1, pK, 1'b0,3'd2,1'b1,1'b1,1'b0, pJ);
    add(1'b0,1'b0,1'b0,1'b1, pL, 1'b0,3'd3,1'b1,1'b1,1'b1, pJ);
    add(1'b0,1'b0,1'b0,1'b1, pM, 1'b0,3'd4,1'b1,1'b0,1'b1, pJ);
    add(1'b0,1'b0,1'b0,1'b1, pN, 1'b1,3'd3,1'b1,1'b1,1'b1, pK);  // full enq+deq
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b1,3'd2,1'b1,1'b1,1'b0, pL);
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b1,3'd1,1'b1,1'b1,1'b0, pM);
    add(1'b0,1'b0,1'b0,1'b0, z,  1'b1,3'd0,1'b0,1'b1,1'b0, z);   // pN was dropped
    add(1'b0,1'b0,1'b0,1'b1, pP, 1'b0,3'd1,1'b1,1'b1,1'b0, pP);  // exception entry
    add(1'b1,1'b1,1'b0,1'b1, pP, 1'b0,3'd0,1'b0,1'b1,1'b0, z);   // flush+rst
    add(1'b0,1'b0,1'b0,1'b1, pP, 1'b0,3'd1,1'b1,1'b1,1'b0, pP);  // re-enqueue
    add(1'b0,1'b1,1'b0,1'b1, pA, 1'b1,3'd0,1'b0,1'b1,1'b0, z);   // flush alone

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].br_e, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      tick();
      chk($sformatf("vec%0d count", i),       DW'(count),       DW'(vecs[i].e_cnt));
      chk($sformatf("vec%0d out_valid", i),   DW'(out_valid),   DW'(vecs[i].e_ov));
      chk($sformatf("vec%0d in_ready", i),    DW'(in_ready),    DW'(vecs[i].e_ir));
      chk($sformatf("vec%0d almost_full", i), DW'(almost_full), DW'(vecs[i].e_af));
      chk($sformatf("vec%0d out_data", i),    out_data,         vecs[i].e_od);
    end

    // Pointer wrap: two resident entries, ten concurrent enq/deq cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    expq.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, pcd(32'h1c001000 + 32'(i * 4)), 1'b0);
      expq.push_back(in_data);
      tick();
    end
    chk("wrap prefill count", DW'(count), DW'(2));
    for (int i = 2; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, pcd(32'h1c001000 + 32'(i * 4)), 1'b1);
      chk($sformatf("wrap head%0d", i), out_data, expq[0]);
      expq.push_back(in_data);
      tick();
      void'(expq.pop_front());
      chk($sformatf("wrap count%0d", i), DW'(count), DW'(2));
    end

    // Drain with X on in_data while in_valid=0; X must never reach out_data.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 'x, 1'b1);
      chk($sformatf("xdrain head%0d", i), out_data, expq[0]);
      tick();
      void'(expq.pop_front());
    end
    chk("xdrain count", DW'(count), DW'(0));
    chk("xdrain out_data zero", out_data, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 'x, 1'b0);
    tick();
    chk("idle x out_data zero", out_data, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
